// File: rtl/dram_if.sv
// ---------------------------------------------------------------------------
// dram_if
//   Pin bundle between a DRAM controller (master) and the behavioural DRAM
//   model (slave). All strobes are active-low.
//
//   CSn   chip select; strobes are ignored while high
//   WEn   write enable, sampled when CAS falls
//   RASn  row address strobe
//   CASn  column address strobe
//   A     multiplexed row/column address
//   D     write data, sampled when CAS falls
//   Q     registered read data (driven by the memory)
// ---------------------------------------------------------------------------
interface dram_if #(
    parameter int word_size = 32,
    parameter int addr_size = 11
);
    logic                 CSn;
    logic                 WEn;
    logic                 RASn;
    logic                 CASn;
    logic [addr_size-1:0] A;
    logic [word_size-1:0] D;
    logic [word_size-1:0] Q;

    modport master (
        output CSn, WEn, RASn, CASn, A, D,
        input  Q
    );

    modport slave (
        input  CSn, WEn, RASn, CASn, A, D,
        output Q
    );
endinterface

// File: rtl/dram.sv
// ---------------------------------------------------------------------------
// dram
//   Synchronous behavioural DRAM with a multiplexed row/column address bus.
//   A falling RASn opens a row (row = A); a later falling CASn supplies the
//   column (col = A) and performs one access at {row, col}:
//     WEn=0 : mem[{row,col}] <= D, Q unchanged
//     WEn=1 : Q <= mem[{row,col}] (valid the cycle after the CAS-fall edge)
//   Page mode: with RASn held low, CASn may rise and fall again to access
//   another column in the same row. Raising RASn closes the row.
//
//   Ports
//     CLK   single clock, all sampling on the rising edge
//     RSTn  asynchronous active-low reset (array contents are kept)
//     bus   dram_if.slave pin bundle (CSn, WEn, RASn, CASn, A, D -> Q)
// ---------------------------------------------------------------------------
module dram #(
    parameter int word_size = 32,
    parameter int addr_size = 11
) (
    input  logic   CLK,
    input  logic   RSTn,
    dram_if.slave  bus
);
    localparam int depth = 1 << (2 * addr_size);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_ROW_OPEN = 2'd1;
    localparam logic [1:0] ST_ACCESS   = 2'd2;

    logic [1:0]             state_reg;
    logic [1:0]             state_next;
    logic [addr_size-1:0]   row_reg;
    logic                   prev_ras_reg;
    logic                   prev_cas_reg;
    logic [word_size-1:0]   q_reg;

    logic                   ras_fall;
    logic                   cas_fall;
    logic                   latch_row;
    logic                   do_access;
    logic                   do_write;
    logic                   do_read;
    logic [2*addr_size-1:0] access_addr;

    logic [word_size-1:0]   mem [0:depth-1];

    // A fall is only meaningful while the chip is selected; the previous-
    // strobe registers keep tracking the pins regardless of CSn so that a
    // strobe already low when CSn drops is not mistaken for a new fall.
    assign ras_fall = !bus.CSn && prev_ras_reg && !bus.RASn;
    assign cas_fall = !bus.CSn && prev_cas_reg && !bus.CASn;

    // Column comes straight off the bus at the CAS-fall edge.
    assign access_addr = {row_reg, bus.A};
    assign do_write    = do_access && !bus.WEn;
    assign do_read     = do_access &&  bus.WEn;

    always_comb begin
        state_next = state_reg;
        latch_row  = 1'b0;
        do_access  = 1'b0;
        if (!bus.CSn) begin
            case (state_reg)
                ST_IDLE: begin
                    // A simultaneous CAS fall is deliberately ignored here:
                    // the controller has to re-strobe CAS once the row is open.
                    if (ras_fall) begin
                        latch_row  = 1'b1;
                        state_next = ST_ROW_OPEN;
                    end
                end
                ST_ROW_OPEN: begin
                    if (bus.RASn) begin
                        state_next = ST_IDLE;
                    end else if (cas_fall) begin
                        do_access  = 1'b1;
                        state_next = ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    // CAS must rise before another fall can be seen, so no
                    // access is started from this state.
                    if (bus.RASn) begin
                        state_next = ST_IDLE;
                    end else if (bus.CASn) begin
                        state_next = ST_ROW_OPEN;
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_reg    <= ST_IDLE;
            row_reg      <= '0;
            prev_ras_reg <= 1'b1;
            prev_cas_reg <= 1'b1;
        end else begin
            state_reg    <= state_next;
            prev_ras_reg <= bus.RASn;
            prev_cas_reg <= bus.CASn;
            if (latch_row) begin
                row_reg <= bus.A;
            end
        end
    end

    // Array is never reset so that data survives a controller reset.
    always_ff @(posedge CLK) begin
        if (do_write) begin
            mem[access_addr] <= bus.D;
        end
    end

    // Registered read port; Q holds its value until the next read or reset.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            q_reg <= '0;
        end else if (do_read) begin
            q_reg <= mem[access_addr];
        end
    end

    assign bus.Q = q_reg;
endmodule

// File: tb/tb_dram.sv
module tb_dram;
    localparam int WW = 32;
    localparam int AW = 4;
    localparam int NW = 1 << (2 * AW);

    logic CLK;
    logic RSTn;

    dram_if #(.word_size(WW), .addr_size(AW)) bus ();

    dram #(.word_size(WW), .addr_size(AW)) dut (
        .CLK  (CLK),
        .RSTn (RSTn),
        .bus  (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Reference model: plain word array plus the value Q should show.
    logic [WW-1:0] model_mem [NW];
    logic [WW-1:0] exp_q;
    logic [AW-1:0] cur_row;
    int n_checks;
    int n_fails;

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [WW-1:0] exp);
        n_checks++;
        assert (bus.Q === exp) else begin
            n_fails++;
            $error("FAIL %s: Q=%h expected %h", tag, bus.Q, exp);
        end
    endtask

    task automatic row_open(input logic [AW-1:0] row);
        bus.CSn  = 1'b0;
        bus.A    = row;
        bus.RASn = 1'b0;
        cur_row  = row;
        cyc();
    endtask

    task automatic precharge();
        bus.CSn  = 1'b0;
        bus.RASn = 1'b1;
        bus.CASn = 1'b1;
        bus.WEn  = 1'b1;
        cyc();
    endtask

    // One CAS pulse writing data; WEn/D are disturbed while CASn stays low
    // and must have no effect.
    task automatic cas_write(input logic [AW-1:0] col, input logic [WW-1:0] data);
        bus.A    = col;
        bus.WEn  = 1'b0;
        bus.D    = data;
        bus.CASn = 1'b0;
        cyc();
        model_mem[{cur_row, col}] = data;
        bus.D    = ~data;
        bus.WEn  = 1'b1;
        cyc();
        bus.CASn = 1'b1;
        bus.WEn  = 1'b0;
        cyc();
        bus.WEn  = 1'b1;
        chk("write_q_unchanged", exp_q);
    endtask

    task automatic cas_read(input logic [AW-1:0] col, input string tag);
        bus.A    = col;
        bus.WEn  = 1'b1;
        bus.CASn = 1'b0;
        cyc();
        exp_q = model_mem[{cur_row, col}];
        chk(tag, exp_q);
        bus.CASn = 1'b1;
        cyc();
        chk("read_hold", exp_q);
    endtask

    // Full write sequence with the chip deselected: nothing may change.
    task automatic cs_blocked_write(input logic [AW-1:0] row, input logic [AW-1:0] col,
                                    input logic [WW-1:0] data);
        bus.CSn  = 1'b1;
        bus.A    = row;
        bus.RASn = 1'b0;
        cyc();
        bus.A    = col;
        bus.WEn  = 1'b0;
        bus.D    = data;
        bus.CASn = 1'b0;
        cyc();
        cyc();
        bus.RASn = 1'b1;
        bus.CASn = 1'b1;
        bus.WEn  = 1'b1;
        cyc();
        bus.CSn  = 1'b0;
        cyc();
        chk("cs_blocked_q", exp_q);
    endtask

    initial begin
        logic [AW-1:0] r;
        logic [AW-1:0] c;
        logic [WW-1:0] d;
        int            nops;

        n_checks = 0;
        n_fails  = 0;
        exp_q    = '0;
        cur_row  = '0;
        RSTn     = 1'b0;
        bus.CSn  = 1'b0;
        bus.WEn  = 1'b1;
        bus.RASn = 1'b1;
        bus.CASn = 1'b1;
        bus.A    = '0;
        bus.D    = '0;

        // Reset
        cyc();
        cyc();
        chk("reset_q", 32'h0);
        RSTn = 1'b1;
        cyc();
        cyc();
        chk("post_reset_q", 32'h0);

        // Basic write / read
        row_open(4'd5);
        cas_write(4'd10, 32'd20);
        precharge();
        chk("write_then_idle_q", 32'h0);
        row_open(4'd5);
        cas_read(4'd10, "read_5_10");
        precharge();
        chk("read_hold_after_precharge", 32'd20);

        // Page mode
        row_open(4'd3);
        cas_write(4'd1, 32'hA);
        cas_write(4'd2, 32'hB);
        precharge();
        row_open(4'd3);
        cas_read(4'd1, "page_read_col1");
        cas_read(4'd2, "page_read_col2");
        precharge();

        // CAS fall with no open row: no write, no read
        bus.A    = 4'd2;
        bus.WEn  = 1'b0;
        bus.D    = 32'h99;
        bus.CASn = 1'b0;
        cyc();
        cyc();
        bus.CASn = 1'b1;
        bus.WEn  = 1'b1;
        cyc();
        bus.A    = 4'd1;
        bus.CASn = 1'b0;
        cyc();
        cyc();
        chk("idle_cas_no_read", exp_q);
        bus.CASn = 1'b1;
        cyc();
        row_open(4'd3);
        cas_read(4'd2, "idle_cas_no_write");
        precharge();

        // Chip deselected during a whole write sequence
        cs_blocked_write(4'd5, 4'd10, 32'h77);
        row_open(4'd5);
        cas_read(4'd10, "cs_blocked_no_write");
        precharge();

        // Simultaneous RAS+CAS fall: row latched, access ignored
        row_open(4'd5);
        cas_write(4'd5, 32'h33);
        precharge();
        bus.A    = 4'd5;
        bus.WEn  = 1'b0;
        bus.D    = 32'h55;
        bus.RASn = 1'b0;
        bus.CASn = 1'b0;
        cur_row  = 4'd5;
        cyc();
        cyc();
        chk("ras_cas_same_edge_q", exp_q);
        bus.CASn = 1'b1;
        bus.WEn  = 1'b1;
        cyc();
        cas_read(4'd10, "restrobe_cas_read");
        precharge();
        row_open(4'd5);
        cas_read(4'd5, "ras_cas_same_edge_no_write");
        precharge();

        // Fill the whole array in page mode
        for (int ri = 0; ri < (1 << AW); ri++) begin
            row_open(AW'(ri));
            for (int ci = 0; ci < (1 << AW); ci++) begin
                cas_write(AW'(ci), $urandom | 32'h1);
            end
            precharge();
        end

        // Randomized mix of accesses
        for (int it = 0; it < 150; it++) begin
            r = AW'($urandom);
            c = AW'($urandom);
            d = $urandom;
            case ($urandom_range(0, 3))
                0: begin
                    row_open(r);
                    cas_write(c, d);
                    precharge();
                end
                1: begin
                    row_open(r);
                    cas_read(c, "rand_read");
                    precharge();
                end
                2: begin
                    nops = $urandom_range(2, 4);
                    row_open(r);
                    for (int k = 0; k < nops; k++) begin
                        c = AW'($urandom);
                        if ($urandom_range(0, 1) == 1) cas_write(c, $urandom);
                        else cas_read(c, "rand_page_read");
                    end
                    precharge();
                end
                default: begin
                    cs_blocked_write(r, c, d);
                end
            endcase
        end

        // Async reset in the middle of an access
        row_open(4'd3);
        bus.A    = 4'd1;
        bus.WEn  = 1'b1;
        bus.CASn = 1'b0;
        cyc();
        exp_q = model_mem[{4'd3, 4'd1}];
        chk("pre_reset_read", exp_q);
        #3;
        RSTn = 1'b0;
        #1;
        exp_q = '0;
        chk("async_reset_q", exp_q);
        bus.RASn = 1'b1;
        bus.CASn = 1'b1;
        cyc();
        cyc();
        RSTn = 1'b1;
        cyc();
        // FSM must be idle: a bare CAS fall does not read
        bus.A    = 4'd2;
        bus.CASn = 1'b0;
        cyc();
        cyc();
        chk("post_reset_idle", exp_q);
        bus.CASn = 1'b1;
        cyc();
        row_open(4'd3);
        cas_read(4'd1, "data_survives_reset");
        cas_read(4'd2, "data_survives_reset_page");
        precharge();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
